bp_axil_mmio_buffer: RTL and testbench

- AXI4-Lite slave: FPGA-side MMIO mailbox between BlackParrot and an AXI-Lite host (nonsynth host in sim, soft/hard CPU on board).
- Buffers 32-bit MMIO words emitted by BP (addr, data pairs serialized as consecutive words) in a request FIFO.
- Host polls the request FIFO via a count register (0x8) and a pop-on-read data register (0xC).
- Host writes MMIO responses to 0x4; they are buffered in a response FIFO and streamed back to BP.

---
 rtl/bp_fpga_host_pkg.sv | 30 +++
 rtl/bp_axil_wr_collector.sv | 65 ++++++
 rtl/bsg_fifo_1r1w_small.sv | 57 +++++
 rtl/bp_axil_mmio_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_bp_axil_mmio_buffer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_fpga_host_pkg.sv
// Shared definitions for the FPGA host MMIO mailbox.
// Contents:
//   - byte offsets of the four MMIO registers
//   - AXI-Lite response codes
//   - read and write FSM state encodings
package bp_fpga_host_pkg;

  // Only bits [3:2] of an offset are decoded by the slave.
  localparam logic [3:0] mmio_resp_free_offset = 4'h0;
  localparam logic [3:0] mmio_resp_offset      = 4'h4;
  localparam logic [3:0] mmio_req_cnt_offset   = 4'h8;
  localparam logic [3:0] mmio_req_offset       = 4'hC;

  typedef enum logic [1:0] {
    e_axi_resp_okay   = 2'b00,
    e_axi_resp_slverr = 2'b10,
    e_axi_resp_decerr = 2'b11
  } axi_resp_e;

  typedef enum logic {
    e_r_idle = 1'b0,
    e_r_resp = 1'b1
  } rd_state_e;

  typedef enum logic {
    e_w_idle = 1'b0,
    e_w_resp = 1'b1
  } wr_state_e;

endpackage

// File: rtl/bp_axil_wr_collector.sv
// AXI-Lite write-channel joiner: captures AW and W independently (either
// order, or the same cycle) and presents one joined write when both exist.
// Ports:
//   clk_i, reset_i        clock, async active-high reset
//   accept                high when the owner can take a new write
//   awaddr/awvalid/awready  AXI-Lite write address channel
//   wdata/wvalid/wready     AXI-Lite write data channel
//   join_v                the joined write happens this cycle
//   join_addr, join_data  address and data of the joined write
module bp_axil_wr_collector #(
  parameter int addr_width_p = 64,
  parameter int data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    accept,
  input  logic [addr_width_p-1:0] awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [data_width_p-1:0] wdata,
  input  logic                    wvalid,
  output logic                    wready,
  output logic                    join_v,
  output logic [addr_width_p-1:0] join_addr,
  output logic [data_width_p-1:0] join_data
);

  logic                    aw_captured_r, w_captured_r;
  logic [addr_width_p-1:0] addr_r;
  logic [data_width_p-1:0] data_r;
  logic                    aw_hs, w_hs;

  assign awready = ~reset_i & accept & ~aw_captured_r;
  assign wready  = ~reset_i & accept & ~w_captured_r;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  // A channel arriving this cycle counts as captured, so a same-cycle AW+W
  // joins immediately without passing through the holding registers.
  assign join_v    = (aw_captured_r | aw_hs) & (w_captured_r | w_hs);
  assign join_addr = aw_captured_r ? addr_r : awaddr;
  assign join_data = w_captured_r ? data_r : wdata;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      aw_captured_r <= 1'b0;
      w_captured_r  <= 1'b0;
      addr_r        <= '0;
      data_r        <= '0;
    end else if (join_v) begin
      aw_captured_r <= 1'b0;
      w_captured_r  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_captured_r <= 1'b1;
        addr_r        <= awaddr;
      end
      if (w_hs) begin
        w_captured_r <= 1'b1;
        data_r       <= wdata;
      end
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO with ready/valid enqueue and yumi dequeue.
// Ports:
//   clk_i, reset_i      clock, async active-high reset (pointers/count only)
//   v_i, ready_o, data_i  enqueue side; push on v_i & ready_o
//   v_o, data_o, yumi_i   dequeue side; yumi_i pops the head (ignored when empty)
//   count_o             current occupancy, 0..els_p
// ready_o depends only on registered occupancy, so a pop while full frees a
// slot for the following cycle rather than the current one.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 32,
  parameter int els_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [width_p-1:0]           data_i,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int cnt_w = $clog2(els_p + 1);
  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w-1:0]   wptr_r, rptr_r;
  logic [cnt_w-1:0]   count_r;
  logic               push, pop;

  assign ready_o = (count_r != cnt_w'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign count_o = count_r;
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  // Pointers wrap explicitly so depths need not be powers of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr_r <= (wptr_r == ptr_w'(els_p - 1)) ? '0 : wptr_r + 1'b1;
      if (pop)  rptr_r <= (rptr_r == ptr_w'(els_p - 1)) ? '0 : rptr_r + 1'b1;
      count_r <= count_r + cnt_w'(push) - cnt_w'(pop);
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_axil_mmio_buffer.sv
// AXI4-Lite MMIO mailbox between BlackParrot and an AXI-Lite host.
// Register map (addr[3:2] decoded, other bits alias):
//   0x0 R  response FIFO free slots      0x4 W  push response word
//   0x8 R  request FIFO occupancy        0xC R  pop request FIFO head
// Ports:
//   clk_i, reset_i   clock, async active-high reset
//   s_axil_*         AXI-Lite slave (prot and wstrb ignored)
//   req_*            BP -> host MMIO words (valid/ready)
//   resp_*           host -> BP MMIO words (valid/ready)
module bp_axil_mmio_buffer
  import bp_fpga_host_pkg::*;
#(
  parameter int S_AXIL_ADDR_WIDTH = 64,
  parameter int S_AXIL_DATA_WIDTH = 32,
  parameter int req_els_p         = 16,
  parameter int resp_els_p        = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,

  input  logic [S_AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                         s_axil_awvalid,
  output logic                         s_axil_awready,
  input  logic [2:0]                   s_axil_awprot,
  input  logic [S_AXIL_DATA_WIDTH-1:0] s_axil_wdata,
  input  logic                         s_axil_wvalid,
  output logic                         s_axil_wready,
  input  logic [3:0]                   s_axil_wstrb,
  output logic                         s_axil_bvalid,
  input  logic                         s_axil_bready,
  output logic [1:0]                   s_axil_bresp,

  input  logic [S_AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  input  logic [2:0]                   s_axil_arprot,
  output logic [S_AXIL_DATA_WIDTH-1:0] s_axil_rdata,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready,
  output logic [1:0]                   s_axil_rresp,

  input  logic                         req_v_i,
  input  logic [31:0]                  req_data_i,
  output logic                         req_ready_and_o,

  output logic                         resp_v_o,
  output logic [31:0]                  resp_data_o,
  input  logic                         resp_ready_and_i
);

  localparam int dw         = S_AXIL_DATA_WIDTH;
  localparam int req_cnt_w  = $clog2(req_els_p + 1);
  localparam int resp_cnt_w = $clog2(resp_els_p + 1);

  // Request FIFO: BP pushes, host pops through 0xC.
  logic                  req_fifo_ready, req_fifo_v, req_yumi;
  logic [31:0]           req_fifo_data;
  logic [req_cnt_w-1:0]  req_count;

  bsg_fifo_1r1w_small #(.width_p(32), .els_p(req_els_p)) req_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (req_v_i),
    .ready_o (req_fifo_ready),
    .data_i  (req_data_i),
    .v_o     (req_fifo_v),
    .data_o  (req_fifo_data),
    .yumi_i  (req_yumi),
    .count_o (req_count)
  );

  assign req_ready_and_o = ~reset_i & req_fifo_ready;

  // Response FIFO: host pushes through 0x4, BP drains.
  logic                  resp_fifo_ready, resp_fifo_v, resp_push;
  logic [31:0]           resp_fifo_data;
  logic [resp_cnt_w-1:0] resp_count;
  logic [dw-1:0]         wr_data;

  bsg_fifo_1r1w_small #(.width_p(32), .els_p(resp_els_p)) resp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (resp_push),
    .ready_o (resp_fifo_ready),
    .data_i  (wr_data[31:0]),
    .v_o     (resp_fifo_v),
    .data_o  (resp_fifo_data),
    .yumi_i  (resp_v_o & resp_ready_and_i),
    .count_o (resp_count)
  );

  // Storage is unreset, so gate the data so BP sees zero when nothing is valid.
  assign resp_v_o    = resp_fifo_v;
  assign resp_data_o = resp_fifo_v ? resp_fifo_data : 32'h0;

  // ---------------- Read path ----------------
  rd_state_e     rd_state_r;
  logic [dw-1:0] rdata_r, rdata_n;
  axi_resp_e     rresp_r, rresp_n;
  logic          ar_hs;

  assign s_axil_arready = ~reset_i & (rd_state_r == e_r_idle);
  assign s_axil_rvalid  = (rd_state_r == e_r_resp);
  assign s_axil_rdata   = rdata_r;
  assign s_axil_rresp   = rresp_r;
  assign ar_hs          = s_axil_arvalid & s_axil_arready;

  // Decode is evaluated in the AR handshake cycle, so counts reflect state
  // before any push landing on the same edge.
  always_comb begin
    rdata_n  = '0;
    rresp_n  = e_axi_resp_okay;
    req_yumi = 1'b0;
    case (s_axil_araddr[3:2])
      mmio_resp_free_offset[3:2]: rdata_n = dw'(resp_els_p) - dw'(resp_count);
      mmio_resp_offset[3:2]:      rdata_n = '0;
      mmio_req_cnt_offset[3:2]:   rdata_n = dw'(req_count);
      mmio_req_offset[3:2]: begin
        if (req_fifo_v) begin
          rdata_n  = dw'(req_fifo_data);
          req_yumi = ar_hs;
        end else begin
          rresp_n  = e_axi_resp_slverr;
        end
      end
      default: rdata_n = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_state_r <= e_r_idle;
      rdata_r    <= '0;
      rresp_r    <= e_axi_resp_okay;
    end else begin
      case (rd_state_r)
        e_r_idle: if (ar_hs) begin
          rdata_r    <= rdata_n;
          rresp_r    <= rresp_n;
          rd_state_r <= e_r_resp;
        end
        e_r_resp: if (s_axil_rready) rd_state_r <= e_r_idle;
        default:  rd_state_r <= e_r_idle;
      endcase
    end
  end

  // ---------------- Write path ----------------
  wr_state_e                wr_state_r;
  axi_resp_e                bresp_r, bresp_n;
  logic                     wr_v;
  logic [S_AXIL_ADDR_WIDTH-1:0] wr_addr;
  logic                     wr_is_resp;

  bp_axil_wr_collector #(
    .addr_width_p (S_AXIL_ADDR_WIDTH),
    .data_width_p (dw)
  ) wr_collector (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .accept    (wr_state_r == e_w_idle),
    .awaddr    (s_axil_awaddr),
    .awvalid   (s_axil_awvalid),
    .awready   (s_axil_awready),
    .wdata     (s_axil_wdata),
    .wvalid    (s_axil_wvalid),
    .wready    (s_axil_wready),
    .join_v    (wr_v),
    .join_addr (wr_addr),
    .join_data (wr_data)
  );

  assign wr_is_resp    = (wr_addr[3:2] == mmio_resp_offset[3:2]);
  assign resp_push     = wr_v & wr_is_resp & resp_fifo_ready;
  assign s_axil_bvalid = (wr_state_r == e_w_resp);
  assign s_axil_bresp  = bresp_r;

  // A full response FIFO drops the word and reports SLVERR.
  always_comb begin
    bresp_n = e_axi_resp_decerr;
    if (wr_is_resp) bresp_n = resp_fifo_ready ? e_axi_resp_okay : e_axi_resp_slverr;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_state_r <= e_w_idle;
      bresp_r    <= e_axi_resp_okay;
    end else begin
      case (wr_state_r)
        e_w_idle: if (wr_v) begin
          bresp_r    <= bresp_n;
          wr_state_r <= e_w_resp;
        end
        e_w_resp: if (s_axil_bready) wr_state_r <= e_w_idle;
        default:  wr_state_r <= e_w_idle;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, s_axil_awprot, s_axil_arprot, s_axil_wstrb,
                       s_axil_araddr[S_AXIL_ADDR_WIDTH-1:4], s_axil_araddr[1:0],
                       wr_addr[S_AXIL_ADDR_WIDTH-1:4], wr_addr[1:0],
                       wr_data[dw-1:0]};

endmodule

// File: tb/tb_bp_axil_mmio_buffer.sv
// Directed bench for bp_axil_mmio_buffer: a vector table of pushes, reads and
// writes with hand-computed results, followed by multi-cycle sequences for
// full request FIFO, write-channel ordering, response overflow and reset.
module tb_bp_axil_mmio_buffer;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam int K_PUSH  = 0;
  localparam int K_READ  = 1;
  localparam int K_WRITE = 2;
  localparam int BOUND   = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] awaddr = '0, araddr = '0;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rvalid, rready = 0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = 4'hF;
  logic [31:0] wdata = '0, rdata;
  logic [1:0]  bresp, rresp;
  logic        req_v = 0, req_ready, resp_v, resp_ready = 0;
  logic [31:0] req_data = '0, resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_axil_mmio_buffer dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .s_axil_awaddr    (awaddr),
    .s_axil_awvalid   (awvalid),
    .s_axil_awready   (awready),
    .s_axil_awprot    (awprot),
    .s_axil_wdata     (wdata),
    .s_axil_wvalid    (wvalid),
    .s_axil_wready    (wready),
    .s_axil_wstrb     (wstrb),
    .s_axil_bvalid    (bvalid),
    .s_axil_bready    (bready),
    .s_axil_bresp     (bresp),
    .s_axil_araddr    (araddr),
    .s_axil_arvalid   (arvalid),
    .s_axil_arready   (arready),
    .s_axil_arprot    (arprot),
    .s_axil_rdata     (rdata),
    .s_axil_rvalid    (rvalid),
    .s_axil_rready    (rready),
    .s_axil_rresp     (rresp),
    .req_v_i          (req_v),
    .req_data_i       (req_data),
    .req_ready_and_o  (req_ready),
    .resp_v_o         (resp_v),
    .resp_data_o      (resp_data),
    .resp_ready_and_i (resp_ready)
  );

  typedef struct {
    int          kind;
    logic [63:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [19];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timedOut(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out after %0d cycles", name, BOUND);
  endtask

  task automatic pushReq(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    req_v = 1'b1;
    req_data = w;
    while (!req_ready && n < BOUND) begin @(negedge clk); n++; end
    if (!req_ready) timedOut("push_wait");
    @(negedge clk);
    req_v = 1'b0;
  endtask

  task automatic axiRead(input logic [63:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    araddr = a;
    arvalid = 1'b1;
    while (!arready && n < BOUND) begin @(negedge clk); n++; end
    if (!arready) timedOut("arready_wait");
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < BOUND) begin @(negedge clk); n++; end
    if (!rvalid) timedOut("rvalid_wait");
    d = rdata;
    r = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // w_lead > 0 presents W that many cycles before AW.
  task automatic axiWrite(input logic [63:0] a, input logic [31:0] d, input int w_lead,
                          output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    if (w_lead > 0) begin
      wdata = d;
      wvalid = 1'b1;
      repeat (w_lead) @(negedge clk);
    end
    awaddr = a;
    awvalid = 1'b1;
    wdata = d;
    wvalid = 1'b1;
    while (!bvalid && n < BOUND) begin @(negedge clk); n++; end
    if (!bvalid) timedOut("bvalid_wait");
    awvalid = 1'b0;
    wvalid = 1'b0;
    r = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, output logic [31:0] d, output logic [1:0] r);
    d = '0;
    r = '0;
    case (v.kind)
      K_PUSH:  pushReq(v.data);
      K_READ:  axiRead(v.addr, d, r);
      default: axiWrite(v.addr, v.data, 0, r);
    endcase
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    vecs[0]  = '{K_PUSH,  64'h0, 32'hA, 32'h0, OKAY};
    vecs[1]  = '{K_PUSH,  64'h0, 32'hB, 32'h0, OKAY};
    vecs[2]  = '{K_PUSH,  64'h0, 32'hC, 32'h0, OKAY};
    vecs[3]  = '{K_READ,  64'h8, 32'h0, 32'd3, OKAY};
    vecs[4]  = '{K_READ,  64'hC, 32'h0, 32'hA, OKAY};
    vecs[5]  = '{K_READ,  64'hC, 32'h0, 32'hB, OKAY};
    vecs[6]  = '{K_READ,  64'hC, 32'h0, 32'hC, OKAY};
    vecs[7]  = '{K_READ,  64'h8, 32'h0, 32'd0, OKAY};
    vecs[8]  = '{K_READ,  64'hC, 32'h0, 32'h0, SLVERR};
    vecs[9]  = '{K_READ,  64'h8, 32'h0, 32'd0, OKAY};
    vecs[10] = '{K_WRITE, 64'h8, 32'h55, 32'h0, DECERR};
    vecs[11] = '{K_WRITE, 64'h0, 32'h66, 32'h0, DECERR};
    vecs[12] = '{K_WRITE, 64'hC, 32'h77, 32'h0, DECERR};
    vecs[13] = '{K_READ,  64'h0, 32'h0, 32'd4, OKAY};
    vecs[14] = '{K_READ,  64'h4, 32'h0, 32'h0, OKAY};
    vecs[15] = '{K_PUSH,  64'h0, 32'h77, 32'h0, OKAY};
    vecs[16] = '{K_READ,  64'hFFFF_0000_0000_000B, 32'h0, 32'd1, OKAY};
    vecs[17] = '{K_READ,  64'h0000_0001_0000_000D, 32'h0, 32'h77, OKAY};
    vecs[18] = '{K_READ,  64'h8, 32'h0, 32'd0, OKAY};

    #3;
    checkOutput("reset_handshake_outs",
                {arready, awready, wready, bvalid, rvalid, req_ready, resp_v}, 7'b0);
    checkOutput("reset_data_outs", {rdata, bresp, rresp, resp_data}, '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_arready", arready, 1'b1);
    checkOutput("idle_req_ready", req_ready, 1'b1);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i], d, r);
      if (vecs[i].kind == K_READ) begin
        checkOutput($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
        checkOutput($sformatf("vec%0d_rresp", i), r, vecs[i].exp_resp);
      end else if (vecs[i].kind == K_WRITE) begin
        checkOutput($sformatf("vec%0d_bresp", i), r, vecs[i].exp_resp);
      end
    end
    checkOutput("decerr_no_resp_push", resp_v, 1'b0);

    // Fill the request FIFO, then pop while BP keeps pushing.
    for (int i = 0; i < 16; i++) pushReq(32'h100 + i);
    checkOutput("full_req_ready", req_ready, 1'b0);
    axiRead(64'h8, d, r);
    checkOutput("full_count", d, 32'd16);
    @(negedge clk);
    req_v = 1'b1;
    req_data = 32'h200;
    fork
      begin
        logic [31:0] pd;
        logic [1:0]  pr;
        axiRead(64'hC, pd, pr);
        checkOutput("full_pop_data", pd, 32'h100);
        checkOutput("full_pop_resp", pr, OKAY);
      end
      begin
        int n = 0;
        while (!req_ready && n < BOUND) begin @(negedge clk); n++; end
        if (!req_ready) timedOut("refill_wait");
        @(negedge clk);
        req_v = 1'b0;
      end
    join
    axiRead(64'h8, d, r);
    checkOutput("refill_count", d, 32'd16);
    for (int i = 1; i <= 16; i++) begin
      axiRead(64'hC, d, r);
      checkOutput($sformatf("drain%0d", i), d, (i == 16) ? 32'h200 : 32'h100 + i);
    end
    axiRead(64'h8, d, r);
    checkOutput("drained_count", d, 32'd0);

    // W two cycles ahead of AW, then overflow the response FIFO.
    axiWrite(64'h4, 32'h1234, 2, r);
    checkOutput("w_first_bresp", r, OKAY);
    checkOutput("single_bvalid", bvalid, 1'b0);
    checkOutput("resp_v_after_write", resp_v, 1'b1);
    checkOutput("resp_data_head", resp_data, 32'h1234);
    for (int i = 1; i < 5; i++) begin
      axiWrite(64'h4, 32'h1234 + i, 0, r);
      checkOutput($sformatf("resp_write%0d_bresp", i + 1), r, (i == 4) ? SLVERR : OKAY);
    end
    axiRead(64'h0, d, r);
    checkOutput("resp_free_full", d, 32'd0);
    checkOutput("resp_head_kept", resp_data, 32'h1234);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("resp_next_word", resp_data, 32'h1235);
    axiRead(64'h0, d, r);
    checkOutput("resp_free_one", d, 32'd1);

    // Reset lands with AW captured and W still outstanding.
    @(negedge clk);
    awaddr = 64'h4;
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    checkOutput("aw_captured_awready", awready, 1'b0);
    checkOutput("aw_captured_wready", wready, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_handshake_outs",
                {arready, awready, wready, bvalid, rvalid, req_ready, resp_v}, 7'b0);
    checkOutput("midreset_data_outs", {rdata, bresp, rresp, resp_data}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    axiRead(64'h8, d, r);
    checkOutput("post_reset_count", d, 32'd0);
    axiRead(64'h0, d, r);
    checkOutput("post_reset_free", d, 32'd4);
    axiWrite(64'h4, 32'hCAFE, 0, r);
    checkOutput("post_reset_bresp", r, OKAY);
    checkOutput("post_reset_resp_v", resp_v, 1'b1);
    checkOutput("post_reset_resp_data", resp_data, 32'hCAFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
